// File: rtl/dmem_responder.sv
// dmem_responder: byte-maskable RAM plus MMIO window (cycle counter, tohost, TX byte FIFO)
// Ports: clk/arst_n (sync active-low reset); mem_addr_in/mem_data_in/mem_we_in/mem_mask_in
// from the core; mem_data_out combinational read data; tx_valid/tx_data/tx_ready FIFO drain;
// tohost register value and done = (tohost != 0).
// CNT_RST_VAL is the counter value loaded on reset (0 in normal use; lets rollover be exercised).
module dmem_responder #(
    parameter int          DATA_WIDTH    = 32,
    parameter int          DMEM_SZ_IN_KB = 1,
    parameter int          TX_DEPTH      = 4,
    parameter logic [63:0] CNT_RST_VAL   = 64'd0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [31:0]           mem_addr_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic                  mem_we_in,
    input  logic [3:0]            mem_mask_in,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic [31:0]           tohost,
    output logic                  done
);
    localparam int WORDS = DMEM_SZ_IN_KB * 256;
    localparam int AW    = $clog2(WORDS);
    localparam int PW    = $clog2(TX_DEPTH);

    logic [31:0]   r_ram [WORDS];
    logic [7:0]    r_fifo [TX_DEPTH];
    logic [63:0]   r_cnt;
    logic [31:0]   r_tohost;
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_count;
    logic          r_ovf;

    logic [AW-1:0] w_idx;
    logic [2:0]    w_off;
    logic [31:0]   w_wmask;
    logic [31:0]   w_status;
    logic          w_mmio_we;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_acc;
    logic          w_pop;
    logic          w_clr;
    logic          w_unused;

    assign w_idx     = mem_addr_in[AW+1:2];
    assign w_off     = mem_addr_in[4:2];
    assign w_wmask   = {{8{mem_mask_in[3]}}, {8{mem_mask_in[2]}}, {8{mem_mask_in[1]}}, {8{mem_mask_in[0]}}};
    assign w_mmio_we = mem_we_in & mem_addr_in[31];
    assign w_full    = r_count == (PW+1)'(TX_DEPTH);
    assign w_empty   = r_count == '0;
    assign w_push    = w_mmio_we & (w_off == 3'd3) & mem_mask_in[0];
    // full is judged on pre-edge state, so a same-edge pop never makes room
    assign w_acc     = w_push & ~w_full;
    assign w_pop     = tx_valid & tx_ready;
    assign w_clr     = w_mmio_we & (w_off == 3'd4) & (|mem_mask_in);
    assign w_status  = {16'd0, 8'(r_count), 5'd0, r_ovf, w_empty, w_full};
    assign w_unused  = ^{mem_addr_in[30:AW+2], mem_addr_in[1:0]};

    assign mem_data_out = !mem_addr_in[31] ? r_ram[w_idx] :
                          w_off == 3'd0    ? r_cnt[31:0]  :
                          w_off == 3'd1    ? r_cnt[63:32] :
                          w_off == 3'd2    ? r_tohost     :
                          w_off == 3'd4    ? w_status     : '0;

    assign tx_valid = ~w_empty;
    assign tx_data  = r_fifo[r_rd];
    assign tohost   = r_tohost;
    assign done     = |r_tohost;

    // storage arrays are not reset, but writes on a reset edge are still discarded
    always_ff @(posedge clk) begin
        if (arst_n && mem_we_in && !mem_addr_in[31])
            r_ram[w_idx] <= (r_ram[w_idx] & ~w_wmask) | (mem_data_in & w_wmask);
        if (arst_n && w_acc)
            r_fifo[r_wr] <= mem_data_in[7:0];
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_cnt    <= CNT_RST_VAL;
            r_tohost <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 64'd1;
            if (w_mmio_we && w_off == 3'd2)
                r_tohost <= (r_tohost & ~w_wmask) | (mem_data_in & w_wmask);
            if (w_acc)
                r_wr <= r_wr + PW'(1);
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            r_count <= r_count + (PW+1)'(w_acc) - (PW+1)'(w_pop);
            if (w_clr)
                r_ovf <= 1'b0;
            else if (w_push && w_full)
                r_ovf <= 1'b1;
        end
    end
endmodule
